// File: rtl/l1a_evt_queue_if.sv
// Bundle of the L1A event-queue signals: trigger-side inputs, readout handshake and status.
// The queue module takes the slave side; the driver of L1A and RD_EN takes the master side.
interface l1a_evt_queue_if #(
  parameter int DEPTH_LOG2 = 4,
  parameter int CNT_W      = 24
);
  logic                  L1A;
  logic [5:1]            L1A_MATCH;
  logic                  LCTERR;
  logic                  L1ACNT_RST;
  logic                  RD_EN;
  logic                  EVT_VALID;
  logic [CNT_W-1:0]      EVT_L1ANUM;
  logic [5:1]            EVT_MATCH;
  logic                  EVT_LCTERR;
  logic                  EVT_NOMATCH;
  logic [DEPTH_LOG2:0]   USED;
  logic                  FULL;
  logic                  EMPTY;
  logic                  OVFL;
  logic [7:0]            DROP_CNT;
  logic [CNT_W-1:0]      L1A_CNT;

  modport master (
    output L1A, L1A_MATCH, LCTERR, L1ACNT_RST, RD_EN,
    input  EVT_VALID, EVT_L1ANUM, EVT_MATCH, EVT_LCTERR, EVT_NOMATCH,
    input  USED, FULL, EMPTY, OVFL, DROP_CNT, L1A_CNT
  );

  modport slave (
    input  L1A, L1A_MATCH, LCTERR, L1ACNT_RST, RD_EN,
    output EVT_VALID, EVT_L1ANUM, EVT_MATCH, EVT_LCTERR, EVT_NOMATCH,
    output USED, FULL, EMPTY, OVFL, DROP_CNT, L1A_CNT
  );
endinterface

// File: rtl/l1a_evt_queue.sv
// L1A event-tag queue: numbers each L1A rising edge, stores {number, match, lcterr} in a
// first-word-fall-through queue and counts events dropped on overflow.
//
// state    | meaning
// ST_FLUSH | one cycle after RST / L1ACNT_RST; rises ignored
// ST_RUN   | rises counted and stored while not full
// ST_OVFL  | rises counted and dropped until the queue has drained to empty
module l1a_evt_queue #(
  parameter int DEPTH_LOG2 = 4,
  parameter int CNT_W      = 24
) (
  input  logic CLK,
  input  logic RST,
  l1a_evt_queue_if.slave bus
);
  localparam int EW = CNT_W + 6;
  localparam logic [DEPTH_LOG2:0]   USED_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   USED_FULL = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;
  localparam logic [CNT_W-1:0]      CNT_ONE   = 1;

  typedef enum logic [1:0] {ST_FLUSH, ST_RUN, ST_OVFL} state_e;

  state_e                state_q, state_d;
  logic                  l1a_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   used_q, used_d;
  logic                  full_q, empty_q;
  logic [CNT_W-1:0]      cnt_q, cnt_next;
  logic                  ovfl_q;
  logic [7:0]            drop_q;
  logic [EW-1:0]         mem_q [1 << DEPTH_LOG2];
  logic [EW-1:0]         head;
  logic                  evt_valid_q, evt_err_q, evt_nomatch_q;
  logic [CNT_W-1:0]      evt_num_q;
  logic [5:1]            evt_match_q;

  logic rise, resync, full_now, pop, load_head;
  logic wr_en, drop_en, cnt_en;

  assign rise     = bus.L1A & ~l1a_q;
  assign resync   = bus.L1ACNT_RST;
  assign full_now = (used_q == USED_FULL);
  // Resync wins over a pop in the same cycle; the flush discards the queue anyway.
  assign pop      = bus.RD_EN & evt_valid_q & ~resync;
  assign cnt_next = cnt_q + CNT_ONE;
  assign head     = mem_q[rd_ptr_q];
  // Valid drops for one cycle after each pop so a held RD_EN cannot pop an unseen entry.
  assign load_head = ~pop & (used_q != '0);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_FLUSH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (resync) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_FLUSH: state_d = ST_RUN;
        ST_RUN:   if (rise && full_now) state_d = ST_OVFL;
        ST_OVFL:  if (used_q == '0) state_d = ST_RUN;
        default:  state_d = ST_FLUSH;
      endcase
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    drop_en = 1'b0;
    cnt_en  = 1'b0;
    if (!resync && !RST) begin
      case (state_q)
        ST_RUN: begin
          cnt_en  = rise;
          wr_en   = rise & ~full_now;
          drop_en = rise & full_now;
        end
        ST_OVFL: begin
          cnt_en  = rise;
          drop_en = rise;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    used_d = used_q;
    if (wr_en && !pop)      used_d = used_q + USED_ONE;
    else if (!wr_en && pop) used_d = used_q - USED_ONE;
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= {cnt_next, bus.L1A_MATCH, bus.LCTERR};
  end

  always_ff @(posedge CLK) begin
    if (RST) l1a_q <= 1'b1;
    else     l1a_q <= bus.L1A;
  end

  always_ff @(posedge CLK) begin
    if (RST || resync) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      used_q        <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      cnt_q         <= '0;
      ovfl_q        <= 1'b0;
      drop_q        <= '0;
      evt_valid_q   <= 1'b0;
      evt_num_q     <= '0;
      evt_match_q   <= '0;
      evt_err_q     <= 1'b0;
      evt_nomatch_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
      used_q  <= used_d;
      full_q  <= (used_d == USED_FULL);
      empty_q <= (used_d == '0);
      if (cnt_en) cnt_q <= cnt_next;
      if (drop_en) begin
        ovfl_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
      evt_valid_q <= load_head;
      if (load_head) begin
        evt_num_q     <= head[EW-1:6];
        evt_match_q   <= head[5:1];
        evt_err_q     <= head[0];
        evt_nomatch_q <= (head[5:1] == '0);
      end
    end
  end

  assign bus.EVT_VALID   = evt_valid_q;
  assign bus.EVT_L1ANUM  = evt_num_q;
  assign bus.EVT_MATCH   = evt_match_q;
  assign bus.EVT_LCTERR  = evt_err_q;
  assign bus.EVT_NOMATCH = evt_nomatch_q;
  assign bus.USED        = used_q;
  assign bus.FULL        = full_q;
  assign bus.EMPTY       = empty_q;
  assign bus.OVFL        = ovfl_q;
  assign bus.DROP_CNT    = drop_q;
  assign bus.L1A_CNT     = cnt_q;
endmodule

// File: tb/tb_l1a_evt_queue.sv
// Self-checking bench for l1a_evt_queue: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_l1a_evt_queue;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic RST2 = 1'b1;
  always #5 CLK = ~CLK;

  l1a_evt_queue_if #(.DEPTH_LOG2(4), .CNT_W(24)) bus ();
  l1a_evt_queue_if #(.DEPTH_LOG2(4), .CNT_W(4))  bus2 ();

  l1a_evt_queue #(.DEPTH_LOG2(4), .CNT_W(24)) dut  (.CLK(CLK), .RST(RST),  .bus(bus));
  l1a_evt_queue #(.DEPTH_LOG2(4), .CNT_W(4))  dut2 (.CLK(CLK), .RST(RST2), .bus(bus2));

  int n_vec = 0;
  int n_err = 0;

  task automatic cyc(input logic l1a, input logic [5:1] m, input logic e,
                     input logic rd, input logic crst);
    bus.L1A = l1a; bus.L1A_MATCH = m; bus.LCTERR = e; bus.RD_EN = rd; bus.L1ACNT_RST = crst;
    @(posedge CLK); #1;
  endtask

  task automatic cyc2(input logic l1a, input logic rd);
    bus2.L1A = l1a; bus2.L1A_MATCH = 5'b01010; bus2.LCTERR = 1'b0; bus2.RD_EN = rd;
    bus2.L1ACNT_RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic fire(input logic [5:1] m, input logic e);
    cyc(1'b1, m, e, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    RST = 1'b1; cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    RST = 1'b0; cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    RST = 1'b1; cyc(1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (bus.EVT_VALID !== 1'b0 || bus.EVT_L1ANUM !== 24'd0 || bus.EVT_MATCH !== 5'd0 ||
                 bus.EVT_LCTERR !== 1'b0 || bus.EVT_NOMATCH !== 1'b0) begin
      n_err++; $display("FAIL reset_head got v=%b n=%0d m=%b want all 0", bus.EVT_VALID, bus.EVT_L1ANUM, bus.EVT_MATCH); end
    n_vec++; if (bus.USED !== 5'd0 || bus.FULL !== 1'b0 || bus.EMPTY !== 1'b1 || bus.OVFL !== 1'b0 ||
                 bus.DROP_CNT !== 8'd0 || bus.L1A_CNT !== 24'd0) begin
      n_err++; $display("FAIL reset_status got used=%0d full=%b empty=%b ovfl=%b drop=%0d cnt=%0d want 0/0/1/0/0/0",
                        bus.USED, bus.FULL, bus.EMPTY, bus.OVFL, bus.DROP_CNT, bus.L1A_CNT); end
    RST = 1'b0;
    repeat (3) cyc(1'b1, 5'b11111, 1'b0, 1'b0, 1'b0);
    n_vec++; if (bus.L1A_CNT !== 24'd0 || bus.USED !== 5'd0) begin
      n_err++; $display("FAIL reset_held_l1a got cnt=%0d used=%0d want 0/0", bus.L1A_CNT, bus.USED); end
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    do_reset();
    cyc(1'b1, 5'b00101, 1'b0, 1'b0, 1'b0);
    n_vec++; if (bus.L1A_CNT !== 24'd1 || bus.USED !== 5'd1 || bus.EVT_VALID !== 1'b0) begin
      n_err++; $display("FAIL basic_write got cnt=%0d used=%0d v=%b want 1/1/0", bus.L1A_CNT, bus.USED, bus.EVT_VALID); end
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (bus.EVT_VALID !== 1'b1 || bus.EVT_L1ANUM !== 24'd1 || bus.EVT_MATCH !== 5'b00101 ||
                 bus.EVT_NOMATCH !== 1'b0 || bus.EVT_LCTERR !== 1'b0) begin
      n_err++; $display("FAIL basic_head got v=%b n=%0d m=%b nm=%b want 1/1/00101/0", bus.EVT_VALID, bus.EVT_L1ANUM, bus.EVT_MATCH, bus.EVT_NOMATCH); end
    cyc(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    n_vec++; if (bus.EMPTY !== 1'b1 || bus.USED !== 5'd0) begin
      n_err++; $display("FAIL basic_pop got empty=%b used=%0d want 1/0", bus.EMPTY, bus.USED); end
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (bus.EVT_VALID !== 1'b0) begin
      n_err++; $display("FAIL basic_after_pop got v=%b want 0", bus.EVT_VALID); end
  endtask

  task automatic test_held_nomatch();
    do_reset();
    repeat (3) cyc(1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (bus.USED !== 5'd1 || bus.L1A_CNT !== 24'd1) begin
      n_err++; $display("FAIL held_count got used=%0d cnt=%0d want 1/1", bus.USED, bus.L1A_CNT); end
    n_vec++; if (bus.EVT_VALID !== 1'b1 || bus.EVT_L1ANUM !== 24'd1 || bus.EVT_NOMATCH !== 1'b1) begin
      n_err++; $display("FAIL held_head got v=%b n=%0d nm=%b want 1/1/1", bus.EVT_VALID, bus.EVT_L1ANUM, bus.EVT_NOMATCH); end
    cyc(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    fire(5'b10000, 1'b1);
    n_vec++; if (bus.EVT_VALID !== 1'b1 || bus.EVT_L1ANUM !== 24'd2 || bus.EVT_LCTERR !== 1'b1 || bus.EVT_NOMATCH !== 1'b0) begin
      n_err++; $display("FAIL held_next got v=%b n=%0d e=%b want 1/2/1", bus.EVT_VALID, bus.EVT_L1ANUM, bus.EVT_LCTERR); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 20; i++) fire(5'(i), 1'b0);
    n_vec++; if (bus.USED !== 5'd16 || bus.FULL !== 1'b1 || bus.OVFL !== 1'b1 ||
                 bus.DROP_CNT !== 8'd4 || bus.L1A_CNT !== 24'd20) begin
      n_err++; $display("FAIL ovfl_status got used=%0d full=%b ovfl=%b drop=%0d cnt=%0d want 16/1/1/4/20",
                        bus.USED, bus.FULL, bus.OVFL, bus.DROP_CNT, bus.L1A_CNT); end
    for (int i = 1; i <= 16; i++) begin
      n_vec++; if (bus.EVT_VALID !== 1'b1 || bus.EVT_L1ANUM !== 24'(i)) begin
        n_err++; $display("FAIL ovfl_drain got v=%b n=%0d want 1/%0d", bus.EVT_VALID, bus.EVT_L1ANUM, i); end
      cyc(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    end
    n_vec++; if (bus.EMPTY !== 1'b1 || bus.EVT_VALID !== 1'b0) begin
      n_err++; $display("FAIL ovfl_empty got empty=%b v=%b want 1/0", bus.EMPTY, bus.EVT_VALID); end
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    fire(5'b00011, 1'b0);
    n_vec++; if (bus.EVT_VALID !== 1'b1 || bus.EVT_L1ANUM !== 24'd21 || bus.OVFL !== 1'b1 || bus.DROP_CNT !== 8'd4) begin
      n_err++; $display("FAIL ovfl_resume got v=%b n=%0d ovfl=%b drop=%0d want 1/21/1/4", bus.EVT_VALID, bus.EVT_L1ANUM, bus.OVFL, bus.DROP_CNT); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    repeat (3) fire(5'b00001, 1'b0);
    cyc(1'b1, 5'b00010, 1'b0, 1'b1, 1'b0);
    n_vec++; if (bus.USED !== 5'd3 || bus.L1A_CNT !== 24'd4) begin
      n_err++; $display("FAIL simul_wr_pop got used=%0d cnt=%0d want 3/4", bus.USED, bus.L1A_CNT); end
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (13) fire(5'b00100, 1'b0);
    n_vec++; if (bus.FULL !== 1'b1 || bus.EVT_VALID !== 1'b1 || bus.EVT_L1ANUM !== 24'd2) begin
      n_err++; $display("FAIL simul_full got full=%b v=%b n=%0d want 1/1/2", bus.FULL, bus.EVT_VALID, bus.EVT_L1ANUM); end
    cyc(1'b1, 5'b01000, 1'b0, 1'b1, 1'b0);
    n_vec++; if (bus.USED !== 5'd15 || bus.DROP_CNT !== 8'd1 || bus.OVFL !== 1'b1 ||
                 bus.FULL !== 1'b0 || bus.L1A_CNT !== 24'd18) begin
      n_err++; $display("FAIL simul_full_drop got used=%0d drop=%0d ovfl=%b full=%b cnt=%0d want 15/1/1/0/18",
                        bus.USED, bus.DROP_CNT, bus.OVFL, bus.FULL, bus.L1A_CNT); end
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_resync();
    do_reset();
    repeat (5) fire(5'b00110, 1'b0);
    n_vec++; if (bus.USED !== 5'd5) begin
      n_err++; $display("FAIL resync_fill got used=%0d want 5", bus.USED); end
    cyc(1'b1, 5'b00001, 1'b0, 1'b1, 1'b1);
    n_vec++; if (bus.EMPTY !== 1'b1 || bus.USED !== 5'd0 || bus.L1A_CNT !== 24'd0 ||
                 bus.OVFL !== 1'b0 || bus.EVT_VALID !== 1'b0) begin
      n_err++; $display("FAIL resync_clear got empty=%b used=%0d cnt=%0d ovfl=%b v=%b want 1/0/0/0/0",
                        bus.EMPTY, bus.USED, bus.L1A_CNT, bus.OVFL, bus.EVT_VALID); end
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 5'b00001, 1'b0, 1'b0, 1'b0);
    n_vec++; if (bus.L1A_CNT !== 24'd0 || bus.USED !== 5'd0) begin
      n_err++; $display("FAIL resync_flush_rise got cnt=%0d used=%0d want 0/0", bus.L1A_CNT, bus.USED); end
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    fire(5'b11111, 1'b1);
    n_vec++; if (bus.EVT_VALID !== 1'b1 || bus.EVT_L1ANUM !== 24'd1 || bus.EVT_LCTERR !== 1'b1 || bus.L1A_CNT !== 24'd1) begin
      n_err++; $display("FAIL resync_first got v=%b n=%0d e=%b cnt=%0d want 1/1/1/1", bus.EVT_VALID, bus.EVT_L1ANUM, bus.EVT_LCTERR, bus.L1A_CNT); end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_num;
    RST2 = 1'b1; cyc2(1'b0, 1'b0);
    RST2 = 1'b0; cyc2(1'b0, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      cyc2(1'b1, 1'b0);
      cyc2(1'b0, 1'b0);
      exp_num = 4'(i);
      n_vec++; if (bus2.EVT_VALID !== 1'b1 || bus2.EVT_L1ANUM !== exp_num) begin
        n_err++; $display("FAIL wrap_num got v=%b n=%0d want 1/%0d", bus2.EVT_VALID, bus2.EVT_L1ANUM, exp_num); end
      cyc2(1'b0, 1'b1);
    end
    cyc2(1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [29:0] q[$];
    int mode;
    logic [23:0] mcnt;
    logic movfl, prev, l1a, e, rd, rst, crst, vobs, rise, leave;
    logic [5:1] m;
    int mdrop, stall;
    do_reset();
    q.delete(); mode = 1; mcnt = '0; movfl = 1'b0; mdrop = 0; prev = 1'b0; stall = 0;
    for (int i = 0; i < 4000; i++) begin
      l1a  = ($urandom_range(0, 99) < 45);
      m    = 5'($urandom);
      e    = 1'($urandom);
      rst  = ($urandom_range(0, 599) == 0);
      crst = ($urandom_range(0, 149) == 0);
      vobs = bus.EVT_VALID;
      rd   = vobs && ($urandom_range(0, 99) < 30);
      if (vobs) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rand_head got valid=1 with n=%0d want empty model queue", bus.EVT_L1ANUM);
        end else if ({bus.EVT_L1ANUM, bus.EVT_MATCH, bus.EVT_LCTERR} !== q[0] ||
                     bus.EVT_NOMATCH !== (q[0][5:1] == 5'd0)) begin
          n_err++; $display("FAIL rand_head got n=%0d m=%b e=%b nm=%b want n=%0d m=%b e=%b",
                            bus.EVT_L1ANUM, bus.EVT_MATCH, bus.EVT_LCTERR, bus.EVT_NOMATCH, q[0][29:6], q[0][5:1], q[0][0]);
        end
      end
      RST = rst;
      cyc(l1a, m, e, rd, crst);
      RST = 1'b0;
      rise = l1a && !prev;
      if (rst || crst) begin
        q.delete(); mode = 0; mcnt = '0; movfl = 1'b0; mdrop = 0; stall = 0;
        prev = rst ? 1'b1 : l1a;
      end else begin
        leave = (mode == 2) && (q.size() == 0);
        if (mode == 0) mode = 1;
        else if (rise) begin
          mcnt = mcnt + 24'd1;
          if (mode == 1 && q.size() < 16) q.push_back({mcnt, m, e});
          else begin movfl = 1'b1; if (mdrop < 255) mdrop++; mode = 2; end
        end
        if (leave) mode = 1;
        if (rd) void'(q.pop_front());
        prev = l1a;
      end
      n_vec++; if (bus.USED !== 5'(q.size()) || bus.FULL !== (q.size() == 16) || bus.EMPTY !== (q.size() == 0)) begin
        n_err++; $display("FAIL rand_occupancy cycle %0d got used=%0d full=%b empty=%b want used=%0d", i, bus.USED, bus.FULL, bus.EMPTY, q.size()); end
      n_vec++; if (bus.L1A_CNT !== mcnt || bus.OVFL !== movfl || bus.DROP_CNT !== 8'(mdrop)) begin
        n_err++; $display("FAIL rand_counters cycle %0d got cnt=%0d ovfl=%b drop=%0d want %0d/%b/%0d",
                          i, bus.L1A_CNT, bus.OVFL, bus.DROP_CNT, mcnt, movfl, mdrop); end
      n_vec++;
      if (q.size() == 0) begin
        stall = 0;
        if (bus.EVT_VALID !== 1'b0) begin n_err++; $display("FAIL rand_valid_empty cycle %0d got v=1 want 0", i); end
      end else if (bus.EVT_VALID === 1'b1) stall = 0;
      else begin
        stall++;
        if (stall > 2) begin n_err++; $display("FAIL rand_valid_latency cycle %0d got v=0 for %0d cycles want <=2", i, stall); end
      end
    end
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.L1A = 1'b0; bus.L1A_MATCH = '0; bus.LCTERR = 1'b0; bus.RD_EN = 1'b0; bus.L1ACNT_RST = 1'b0;
    bus2.L1A = 1'b0; bus2.L1A_MATCH = '0; bus2.LCTERR = 1'b0; bus2.RD_EN = 1'b0; bus2.L1ACNT_RST = 1'b0;
    test_reset();
    test_basic();
    test_held_nomatch();
    test_overflow();
    test_simultaneous();
    test_resync();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish within 2000000 time units");
    $fatal(1);
  end
endmodule

// File: doc/l1a_evt_queue.md
# l1a_evt_queue

Event-tag queue directly downstream of the trigger control stage. On every L1A delivered to the CFEBs it assigns a 24-bit L1A number and captures the per-CFEB LCT/L1A match pattern and the LCT error flag present in the same cycle. The entry goes into a first-word-fall-through queue, which the DAQ readout controller drains one event at a time. Overflow is handled explicitly: L1As stay counted while entries are dropped and flagged.

## Interface
- DEPTH_LOG2, default 4: queue depth is 2^DEPTH_LOG2 entries.
- CNT_W, default 24: L1A number width.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- L1A  in  1  L1A to CFEBs, which may be held more than one cycle. Only the rising edge counts as one L1A.
- L1A_MATCH  in  5  per-CFEB match bits [5:1], valid in the L1A rising-edge cycle.
- LCTERR  in  1  LCT error flag, valid in the L1A rising-edge cycle.
- L1ACNT_RST  in  1  resync: clears the L1A number and flushes the queue.
- RD_EN  in  1  pop request from the readout controller.
- EVT_VALID  out  1  head entry is valid.
- EVT_L1ANUM  out  CNT_W  L1A number of the head entry.
- EVT_MATCH  out  5  match bits of the head entry.
- EVT_LCTERR  out  1  LCT error of the head entry.
- EVT_NOMATCH  out  1  head entry has all match bits zero.
- USED  out  DEPTH_LOG2+1  current occupancy.
- FULL  out  1  USED == 2^DEPTH_LOG2.
- EMPTY  out  1  USED == 0.
- OVFL  out  1  sticky flag: one or more events were dropped.
- DROP_CNT  out  8  count of dropped events, saturating at 255.
- L1A_CNT  out  CNT_W  running L1A number.

## Operation
- Edge detect: l1a_q is L1A registered. A rise is `L1A & ~l1a_q`. l1a_q resets to 1, so an L1A held high through reset release does not count.
- State machine:
  - FLUSH: entered on RST or L1ACNT_RST. Lasts exactly one cycle, then goes to RUN. Rises seen in FLUSH are neither counted nor stored.
  - RUN, on a rise:
    - L1A_CNT increments; the value stored is the incremented value, so the first event after reset is 1. The counter wraps from 2^CNT_W−1 to 0.
    - If not FULL, write {L1A_CNT+1, L1A_MATCH, LCTERR}.
    - If FULL, the event is dropped: OVFL set, DROP_CNT incremented, state goes to OVFL.
  - OVFL, on a rise: counted, never stored, DROP_CNT incremented. State returns to RUN in the cycle after USED reaches 0.
- FULL is evaluated before the pop. A rise coinciding with RD_EN while FULL is dropped, and the pop still occurs.
- Read: when EVT_VALID is high, RD_EN pops the head entry and the next entry appears on the following cycle. RD_EN while EMPTY is ignored.
- Simultaneous write and pop when not FULL: USED is unchanged and both take effect.
- Flush (RST or L1ACNT_RST): pointers cleared, USED=0, L1A_CNT=0, OVFL=0, DROP_CNT=0.
  - L1ACNT_RST has priority over a rise and over RD_EN in the same cycle.
  - RST clears all state identically.
- Pointers are DEPTH_LOG2 bits wide and wrap naturally. USED is tracked separately to distinguish full from empty.

## Timing
- Reset values, from the cycle after RST is sampled:
  - EVT_VALID=0, EVT_L1ANUM=0, EVT_MATCH=0, EVT_LCTERR=0, EVT_NOMATCH=0.
  - USED=0, FULL=0, EMPTY=1, OVFL=0, DROP_CNT=0, L1A_CNT=0.
  - State FLUSH.
- All outputs are registered.
- L1A rise sampled at edge n:
  - L1A_CNT is updated after edge n.
  - The entry is written at edge n.
  - If the queue was empty, EVT_VALID and the head fields show the entry after edge n+1. This is 2-cycle rise-to-valid latency.
- Pop with RD_EN at edge m: the next head, or EVT_VALID=0, is shown after edge m+1. The head fields are stable while EVT_VALID=1 and RD_EN=0.
- FULL, EMPTY and USED update after the same edge as the write or pop.
- Minimum L1A spacing is 2 cycles: a rise needs a low cycle before it. Back-to-back rises at that spacing are all stored while not FULL.

## Test plan
- Basic event: after reset, L1A high 1 cycle with L1A_MATCH=5'b00101 and LCTERR=0.
  - Two cycles later EVT_VALID=1, EVT_L1ANUM=1, EVT_MATCH=5'b00101, EVT_NOMATCH=0.
  - RD_EN pops the entry; EMPTY=1 next cycle.
- Held and no-match L1A: L1A held high 3 cycles with L1A_MATCH=0.
  - Exactly one entry: L1ANUM=1, EVT_NOMATCH=1.
  - A subsequent L1A produces L1ANUM=2.
- Overflow: 20 L1As, 2 cycles apart, no reads.
  - USED=16, FULL=1, OVFL=1, DROP_CNT=4, L1A_CNT=20.
  - Draining yields numbers 1–16.
  - The next L1A after empty is stored as 21; OVFL stays 1.
- Simultaneous events at USED=3:
  - Rise plus RD_EN in the same cycle: USED stays 3.
  - At FULL, rise plus RD_EN: event dropped, USED=15, DROP_CNT+1.
- Resync: queue holds 5 entries; L1ACNT_RST asserted together with a rise.
  - Next cycle: EMPTY=1, L1A_CNT=0, OVFL=0, EVT_VALID=0.
  - A rise in the FLUSH cycle is ignored.
  - The next accepted L1A is numbered 1.
- Wrap: with CNT_W=4, 17 L1As with reads.
  - Stored numbers run 1…15, 0, 1.
